// File: rtl/jts16_adc_pkg.sv
// ============================================================================
// Module   : jts16_adc_pkg
// Purpose  : Shared types and helpers for the System 16B serial ADC model.
//            Holds the controller state encoding, the address-width helper
//            and the default fill bit.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package jts16_adc_pkg;

  // Controller state. Explicit 2-bit encoding.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CONV  = 2'd1,
    ST_READY = 2'd2
  } adc_state_e;

  // Bit returned once the sample is exhausted, while busy, or for a bad channel.
  localparam logic FILL_DEFAULT = 1'b1;

  // Address width: channel index bits plus one MSB that flags an invalid channel.
  function automatic int chan_w(input int channels);
    return $clog2(channels) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/jts16_adc_shreg.sv
// ============================================================================
// Module   : jts16_adc_shreg
// Purpose  : DW-bit loadable shift register with a count of unread bits.
//            The head bit is the MSB when MSB_FIRST=1, else the LSB. Each
//            shift moves data toward the head and inserts fill_i at the tail.
// Ports    : clk, rst        - clock, synchronous active-high reset
//            fill_i          - bit inserted on shift (and reset pattern)
//            load_i, data_i  - parallel load (highest priority), sets count=DW
//            clr_i           - discard remaining bits (count=0)
//            shift_i         - shift one bit if any remain
//            head_o          - current head bit
//            bits_left_o     - unread bits remaining
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module jts16_adc_shreg #(
  parameter int DW        = 8,
  parameter bit MSB_FIRST = 1'b1,
  localparam int BLW      = $clog2(DW + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           fill_i,
  input  logic           load_i,
  input  logic [DW-1:0]  data_i,
  input  logic           clr_i,
  input  logic           shift_i,
  output logic           head_o,
  output logic [BLW-1:0] bits_left_o
);

  logic [DW-1:0]  sr_q;
  logic [DW-1:0]  sr_shifted_d;
  logic [BLW-1:0] bits_left_q;

  // Shift expressions are written so that DW=1 degenerates to "take fill_i".
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign head_o       = sr_q[DW-1];
      assign sr_shifted_d = (sr_q << 1) | DW'(fill_i);
    end else begin : g_lsb_first
      assign head_o       = sr_q[0];
      assign sr_shifted_d = (sr_q >> 1) | (DW'(fill_i) << (DW - 1));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q        <= {DW{fill_i}};
      bits_left_q <= '0;
    end else if (load_i) begin
      sr_q        <= data_i;
      bits_left_q <= BLW'(DW);
    end else if (clr_i) begin
      bits_left_q <= '0;
    end else if (shift_i && (bits_left_q != '0)) begin
      // Count saturates at zero: no shift is accepted once empty.
      sr_q        <= sr_shifted_d;
      bits_left_q <= bits_left_q - BLW'(1);
    end
  end

  assign bits_left_o = bits_left_q;

endmodule

`default_nettype wire

// File: rtl/jts16_adc_serial.sv
// ============================================================================
// Module   : jts16_adc_serial
// Purpose  : Serial-output ADC emulation for System 16B analogue controls.
//            A CPU write selects a channel and starts a conversion; after
//            CONV_CYCLES+1 clocks the channel value is latched, then each
//            completed CPU read shifts out one bit.
// Ports    : clk, rst     - clock, synchronous active-high reset
//            cs_i, wr_i   - chip select / write qualifier from I/O decoder
//            addr_i       - channel select on write, MSB set = invalid
//            ana_i        - packed channel values, channel 0 in LSBs
//            sdo_o        - serial data bit for the CPU
//            busy_o       - conversion in progress
//            bits_left_o  - unread bits remaining
// Options  : JTS16_ADC_SIGNED_EN - treat channels as two's complement and
//            latch them as offset binary (sample MSB inverted).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module jts16_adc_serial
  import jts16_adc_pkg::*;
#(
  parameter int   CHANNELS    = 4,
  parameter int   DW          = 8,
  parameter int   CONV_CYCLES = 32,
  parameter bit   MSB_FIRST   = 1'b1,
  parameter logic FILL        = FILL_DEFAULT,
  localparam int  AW          = chan_w(CHANNELS),
  localparam int  BLW         = $clog2(DW + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cs_i,
  input  logic                   wr_i,
  input  logic [AW-1:0]          addr_i,
  input  logic [CHANNELS*DW-1:0] ana_i,
  output logic                   sdo_o,
  output logic                   busy_o,
  output logic [BLW-1:0]         bits_left_o
);

  localparam int CW = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;

  adc_state_e     state_q;
  logic [CW-1:0]  cnt_q;
  logic [AW-1:0]  chan_q;
  logic           busy_q;
  logic           cs_q;
  logic           rd_q;

  logic           wr_start_d;
  logic           rd_end_d;
  logic           load_d;
  logic           shift_d;
  logic [DW-1:0]  sample_d;
  logic           head;
  logic [BLW-1:0] bits_left;

  // Access edges: a write begins on the first cs cycle after cs was low;
  // a read ends on the cycle cs drops after a read cycle.
  assign wr_start_d = cs_i && wr_i && !cs_q;
  assign rd_end_d   = rd_q && !cs_i;

  // A write start suppresses any latch or shift in the same cycle.
  assign load_d  = !wr_start_d && (state_q == ST_CONV) && (cnt_q == '0);
  assign shift_d = !wr_start_d && (state_q == ST_READY) && rd_end_d;

  // Channel mux. An address with its MSB set is never below CHANNELS, so it
  // falls through to the all-FILL default along with out-of-range indices.
  always_comb begin
    sample_d = {DW{FILL}};
    for (int c = 0; c < CHANNELS; c++) begin
      if (chan_q == AW'(c)) begin
        sample_d = ana_i[c*DW +: DW];
`ifdef JTS16_ADC_SIGNED_EN
        // Two's complement to offset binary.
        sample_d[DW-1] = ~ana_i[c*DW + DW - 1];
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      chan_q  <= '0;
      busy_q  <= 1'b0;
      cs_q    <= 1'b0;
      rd_q    <= 1'b0;
    end else begin
      cs_q <= cs_i;
      rd_q <= cs_i && !wr_i;
      if (wr_start_d) begin
        chan_q  <= addr_i;
        cnt_q   <= CW'(CONV_CYCLES - 1);
        busy_q  <= 1'b1;
        state_q <= ST_CONV;
      end else begin
        case (state_q)
          ST_CONV: begin
            if (cnt_q == '0) begin
              busy_q  <= 1'b0;
              state_q <= ST_READY;
            end else begin
              cnt_q <= cnt_q - CW'(1);
            end
          end
          ST_READY: begin
            // Leave READY as the last unread bit is consumed.
            if (bits_left == '0 || (rd_end_d && bits_left == BLW'(1))) begin
              state_q <= ST_IDLE;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  jts16_adc_shreg #(
    .DW        (DW),
    .MSB_FIRST (MSB_FIRST)
  ) u_shreg (
    .clk         (clk),
    .rst         (rst),
    .fill_i      (FILL),
    .load_i      (load_d),
    .data_i      (sample_d),
    .clr_i       (wr_start_d),
    .shift_i     (shift_d),
    .head_o      (head),
    .bits_left_o (bits_left)
  );

  assign sdo_o       = (state_q == ST_READY) ? head : FILL;
  assign busy_o      = busy_q;
  assign bits_left_o = bits_left;

endmodule

`default_nettype wire

// File: tb/tb_jts16_adc_serial.sv
// ============================================================================
// Module   : tb_jts16_adc_serial
// Purpose  : Directed self-checking bench for jts16_adc_serial. Two DUTs
//            share the bus: one MSB-first (default), one LSB-first.
//            Honours JTS16_ADC_SIGNED_EN when computing expected samples.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_jts16_adc_serial;

  localparam int CONV = 32;
`ifdef JTS16_ADC_SIGNED_EN
  localparam logic [7:0] SFLIP = 8'h80;
`else
  localparam logic [7:0] SFLIP = 8'h00;
`endif
  localparam logic [31:0] ANA_INIT = 32'h96_A5_3C_01;

  logic        clk = 1'b0;
  logic        rst;
  logic        cs;
  logic        wr;
  logic [2:0]  addr;
  logic [31:0] ana;
  logic        sdo, sdo_l, busy, busy_l;
  logic [3:0]  bl, bl_l;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  jts16_adc_serial #(.CHANNELS(4), .DW(8), .CONV_CYCLES(CONV), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst), .cs_i(cs), .wr_i(wr), .addr_i(addr), .ana_i(ana),
    .sdo_o(sdo), .busy_o(busy), .bits_left_o(bl)
  );

  jts16_adc_serial #(.CHANNELS(4), .DW(8), .CONV_CYCLES(CONV), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .cs_i(cs), .wr_i(wr), .addr_i(addr), .ana_i(ana),
    .sdo_o(sdo_l), .busy_o(busy_l), .bits_left_o(bl_l)
  );

  // Write access: one cs cycle with wr high. Returns at the first negedge
  // after the write-start edge.
  task automatic do_write(input logic [2:0] a);
    @(negedge clk); cs = 1'b1; wr = 1'b1; addr = a;
    @(negedge clk); cs = 1'b0; wr = 1'b0;
  endtask

  // Read access: sdo sampled mid-access, bits_left sampled after cs drops.
  task automatic do_read(output logic s, output logic sl,
                         output logic [3:0] b, output logic [3:0] bll);
    @(negedge clk); cs = 1'b1; wr = 1'b0;
    @(negedge clk); s = sdo; sl = sdo_l; cs = 1'b0;
    @(negedge clk); b = bl; bll = bl_l;
  endtask

  // Cycles counted from the write-start cycle until busy reads low.
  task automatic wait_low(output int n);
    n = 1;
    while (busy === 1'b1 && n < 200) begin
      @(negedge clk); n++;
    end
  endtask

  task automatic test_reset();
    logic s, sl; logic [3:0] b, bll;
    rst = 1'b1; cs = 1'b0; wr = 1'b0; addr = '0; ana = ANA_INIT;
    repeat (3) @(negedge clk);
    checks++; if (sdo !== 1'b1) begin errors++; $display("FAIL rst_sdo got %b exp 1", sdo); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
    checks++; if (bl !== 4'd0) begin errors++; $display("FAIL rst_bits_left got %0d exp 0", bl); end
    rst = 1'b0;
    do_read(s, sl, b, bll);
    checks++; if (s !== 1'b1) begin errors++; $display("FAIL idle_read_sdo got %b exp 1", s); end
    checks++; if (b !== 4'd0) begin errors++; $display("FAIL idle_read_bits got %0d exp 0", b); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_read_busy got %b exp 0", busy); end
  endtask

  task automatic test_conv_msb();
    logic s, sl; logic [3:0] b, bll; int n;
    logic [7:0] exp_w;
    exp_w = 8'b1010_0101 ^ SFLIP;
    do_write(3'd2);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL conv_busy_rise got %b exp 1", busy); end
    wait_low(n);
    checks++; if (n != CONV + 1) begin errors++; $display("FAIL conv_latency got %0d exp %0d", n, CONV + 1); end
    checks++; if (bl !== 4'd8) begin errors++; $display("FAIL conv_bits_left got %0d exp 8", bl); end
    for (int i = 0; i < 8; i++) begin
      do_read(s, sl, b, bll);
      checks++; if (s !== exp_w[7-i]) begin errors++; $display("FAIL msb_bit%0d got %b exp %b", i, s, exp_w[7-i]); end
      checks++; if (b !== 4'(7-i)) begin errors++; $display("FAIL msb_left%0d got %0d exp %0d", i, b, 7-i); end
    end
    do_read(s, sl, b, bll);
    checks++; if (s !== 1'b1) begin errors++; $display("FAIL msb_ninth got %b exp 1", s); end
    checks++; if (b !== 4'd0) begin errors++; $display("FAIL msb_ninth_left got %0d exp 0", b); end
  endtask

  task automatic test_lsb();
    logic s, sl; logic [3:0] b, bll; int n;
    logic [7:0] exp_w;
    exp_w = 8'h01 ^ SFLIP;
    do_write(3'd0);
    wait_low(n);
    for (int i = 0; i < 8; i++) begin
      do_read(s, sl, b, bll);
      checks++; if (sl !== exp_w[i]) begin errors++; $display("FAIL lsb_bit%0d got %b exp %b", i, sl, exp_w[i]); end
      checks++; if (s !== exp_w[7-i]) begin errors++; $display("FAIL ch0_msb_bit%0d got %b exp %b", i, s, exp_w[7-i]); end
    end
    checks++; if (bll !== 4'd0) begin errors++; $display("FAIL lsb_left got %0d exp 0", bll); end
  endtask

  task automatic test_invalid();
    logic s, sl; logic [3:0] b, bll; int n;
    do_write(3'b100);
    wait_low(n);
    checks++; if (bl !== 4'd8) begin errors++; $display("FAIL inv_bits_left got %0d exp 8", bl); end
    for (int i = 0; i < 8; i++) begin
      do_read(s, sl, b, bll);
      checks++; if (s !== 1'b1) begin errors++; $display("FAIL inv_bit%0d got %b exp 1", i, s); end
      checks++; if (b !== 4'(7-i)) begin errors++; $display("FAIL inv_left%0d got %0d exp %0d", i, b, 7-i); end
    end
  endtask

  task automatic test_restart();
    logic s, sl; logic [3:0] b, bll; int n;
    logic [7:0] exp_w;
    exp_w = 8'h96 ^ SFLIP;
    do_write(3'd1);                 // write start presented at cycle 0
    do_read(s, sl, b, bll);         // read while converting: fill, no shift
    checks++; if (s !== 1'b1) begin errors++; $display("FAIL conv_read_sdo got %b exp 1", s); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL conv_read_busy got %b exp 1", busy); end
    checks++; if (b !== 4'd0) begin errors++; $display("FAIL conv_read_left got %0d exp 0", b); end
    repeat (5) @(negedge clk);
    do_write(3'd3);                 // write start presented at cycle 10
    wait_low(n);
    checks++; if (n != CONV + 1) begin errors++; $display("FAIL restart_latency got %0d exp %0d", n, CONV + 1); end
    checks++; if (bl !== 4'd8) begin errors++; $display("FAIL restart_left got %0d exp 8", bl); end
    ana = 32'h5A_5A_5A_5A;          // must not disturb the latched sample
    for (int i = 0; i < 8; i++) begin
      do_read(s, sl, b, bll);
      checks++; if (s !== exp_w[7-i]) begin errors++; $display("FAIL restart_bit%0d got %b exp %b", i, s, exp_w[7-i]); end
    end
    ana = ANA_INIT;
  endtask

  task automatic test_back_to_back();
    logic s, sl; logic [3:0] b, bll; int n;
    logic [7:0] exp_w;
    exp_w = 8'h3C ^ SFLIP;
    do_write(3'd2);
    wait_low(n);
    repeat (3) do_read(s, sl, b, bll);
    checks++; if (b !== 4'd5) begin errors++; $display("FAIL partial_left got %0d exp 5", b); end
    do_write(3'd1);                 // discards the remaining five bits
    checks++; if (bl !== 4'd0) begin errors++; $display("FAIL discard_left got %0d exp 0", bl); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL discard_busy got %b exp 1", busy); end
    wait_low(n);
    checks++; if (n != CONV + 1) begin errors++; $display("FAIL b2b_latency got %0d exp %0d", n, CONV + 1); end
    do_read(s, sl, b, bll);
    checks++; if (s !== exp_w[7]) begin errors++; $display("FAIL b2b_first got %b exp %b", s, exp_w[7]); end
    checks++; if (b !== 4'd7) begin errors++; $display("FAIL b2b_left got %0d exp 7", b); end
  endtask

  task automatic test_signed();
    logic s, sl; logic [3:0] b, bll; int n;
    logic [7:0] exp_w;
    exp_w = 8'h00 ^ SFLIP;
    ana[7:0] = 8'h00;
    do_write(3'd0);
    wait_low(n);
    for (int i = 0; i < 8; i++) begin
      do_read(s, sl, b, bll);
      checks++; if (s !== exp_w[7-i]) begin errors++; $display("FAIL zero_bit%0d got %b exp %b", i, s, exp_w[7-i]); end
    end
    ana = ANA_INIT;
  endtask

  initial begin
    test_reset();
    test_conv_msb();
    test_lsb();
    test_invalid();
    test_restart();
    test_back_to_back();
    test_signed();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
